// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared types and constants for the HPS I/O bus controller.
// Holds the FSM encoding, control-region offsets and error/ID constants.
package io_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESPOND,
      ST_RECOVER
   } state_t;

   localparam logic [3:0]  REGION_CTRL    = 4'hF;

   localparam logic [1:0]  OFF_IRQ_RAW    = 2'd0;
   localparam logic [1:0]  OFF_IRQ_MASK   = 2'd1;
   localparam logic [1:0]  OFF_ERR_STATUS = 2'd2;
   localparam logic [1:0]  OFF_ID         = 2'd3;

   localparam logic [15:0] ERR_DATA       = 16'hDEAD;
   localparam logic [15:0] ID_VALUE       = 16'h0391;

   localparam int          ERR_TIMEOUT    = 0;
   localparam int          ERR_DECODE     = 1;
   localparam int          MASK_ERR_EN    = 15;

   // Expand the 2-bit byte enable into a 16-bit bit mask.
   function automatic logic [15:0] be_mask(input logic [1:0] be);
      return {{8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/io_irq_ctrl.sv
// io_irq_ctrl: IRQ_MASK / ERR_STATUS registers and the merged io_irq.
// Ports: s_irq levels, register write strobes, error set events, io_irq.
module io_irq_ctrl
   import io_bus_pkg::*;
#(
   parameter int NUM_SLV = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SLV-1:0] s_irq,
   input  logic               mask_wr,
   input  logic               err_wr,
   input  logic [1:0]         byte_enable,
   input  logic [15:0]        write_data,
   input  logic [1:0]         err_set,
   input  logic [3:0]         err_region,
   output logic [15:0]        irq_mask,
   output logic [15:0]        err_status,
   output logic               io_irq
);

   // Only per-port enables and the error enable are implemented.
   localparam logic [15:0] MASK_BITS =
      16'h8000 | 16'((1 << NUM_SLV) - 1);

   logic [15:0] bm;
   logic [15:0] mask_next;
   logic [15:0] err_next;

   always_comb begin
      bm        = be_mask(byte_enable);
      mask_next = ((irq_mask & ~bm) | (write_data & bm)) & MASK_BITS;
      err_next  = err_status;
      if (err_wr)
         err_next = err_status & ~(write_data & bm);
      // Error events are applied after the W1C so a set always wins.
      if (|err_set) begin
         err_next[1:0]   = err_next[1:0] | err_set;
         err_next[15:12] = err_region;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_mask   <= '0;
         err_status <= '0;
         io_irq     <= 1'b0;
      end else begin
         if (mask_wr)
            irq_mask <= mask_next;
         err_status <= err_next;
         io_irq     <= (|(s_irq & irq_mask[NUM_SLV-1:0]))
                     | (irq_mask[MASK_ERR_EN] & (|err_status[1:0]));
      end
   end

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: HPS I/O bridge bus controller with decode and timeout.
// Ports: io_* bridge side, s_* peripheral side, io_irq merged interrupt.
module io_bus_ctrl
   import io_bus_pkg::*;
#(
   parameter int NUM_SLV = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  io_bus_enable,
   input  logic [15:0]           io_address,
   input  logic                  io_rw,
   input  logic [1:0]            io_byte_enable,
   input  logic [15:0]           io_write_data,
   output logic [15:0]           io_read_data,
   output logic                  io_acknowledge,
   output logic                  io_irq,
   output logic [NUM_SLV-1:0]    s_sel,
   output logic [11:0]           s_address,
   output logic                  s_rw,
   output logic [1:0]            s_byte_enable,
   output logic [15:0]           s_write_data,
   input  logic [16*NUM_SLV-1:0] s_read_data,
   input  logic [NUM_SLV-1:0]    s_ack,
   input  logic [NUM_SLV-1:0]    s_irq
);

   state_t              state;
   logic [3:0]          region_q;
   logic [15:0]         timer;

   logic [3:0]          region;
   logic                is_ctrl;
   logic                is_slv;
   logic                req;
   logic                reg_hit;
   logic [NUM_SLV-1:0]  slv_onehot;
   logic                sel_ack;
   logic [15:0]         sel_data;
   logic                timeout;
   logic [15:0]         reg_rdata;
   logic                reg_wr;
   logic                mask_wr;
   logic                err_wr;
   logic [1:0]          err_set;
   logic [3:0]          err_region;
   logic [15:0]         irq_mask;
   logic [15:0]         err_status;

   assign region  = io_address[15:12];
   assign is_ctrl = region == REGION_CTRL;
   assign is_slv  = int'(region) < NUM_SLV;
   assign req     = state == ST_IDLE && io_bus_enable;
   assign reg_hit = io_address[11:3] == '0;
   assign timeout = timer == 16'(TIMEOUT - 1);

   always_comb begin
      slv_onehot = '0;
      sel_ack    = 1'b0;
      sel_data   = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         slv_onehot[i] = int'(region) == i;
         if (s_sel[i]) begin
            sel_ack  = sel_ack | s_ack[i];
            sel_data = sel_data | s_read_data[16*i +: 16];
         end
      end
   end

   always_comb begin
      reg_rdata = '0;
      if (reg_hit) begin
         unique case (io_address[2:1])
            OFF_IRQ_RAW:    reg_rdata = 16'(s_irq);
            OFF_IRQ_MASK:   reg_rdata = irq_mask;
            OFF_ERR_STATUS: reg_rdata = err_status;
            OFF_ID:         reg_rdata = ID_VALUE;
         endcase
      end
   end

   assign reg_wr  = req && is_ctrl && !io_rw && reg_hit;
   assign mask_wr = reg_wr && io_address[2:1] == OFF_IRQ_MASK;
   assign err_wr  = reg_wr && io_address[2:1] == OFF_ERR_STATUS;

   always_comb begin
      err_set = '0;
      err_set[ERR_DECODE]  = req && !is_ctrl && !is_slv;
      err_set[ERR_TIMEOUT] = state == ST_ACCESS && !sel_ack && timeout;
   end

   assign err_region = (state == ST_IDLE) ? region : region_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         io_acknowledge <= 1'b0;
         io_read_data   <= '0;
         s_sel          <= '0;
         s_address      <= '0;
         s_rw           <= 1'b0;
         s_byte_enable  <= '0;
         s_write_data   <= '0;
         region_q       <= '0;
         timer          <= '0;
      end else begin
         io_acknowledge <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (io_bus_enable) begin
                  s_address     <= io_address[11:0];
                  s_rw          <= io_rw;
                  s_byte_enable <= io_byte_enable;
                  s_write_data  <= io_write_data;
                  region_q      <= region;
                  timer         <= '0;
                  unique case (1'b1)
                     is_ctrl: begin
                        state          <= ST_RESPOND;
                        io_acknowledge <= 1'b1;
                        io_read_data   <= io_rw ? reg_rdata : '0;
                     end
                     is_slv: begin
                        state <= ST_ACCESS;
                        s_sel <= slv_onehot;
                     end
                     default: begin
                        state          <= ST_RESPOND;
                        io_acknowledge <= 1'b1;
                        io_read_data   <= io_rw ? ERR_DATA : '0;
                     end
                  endcase
               end
            end
            ST_ACCESS: begin
               timer <= timer + 16'd1;
               if (sel_ack) begin
                  state          <= ST_RESPOND;
                  io_acknowledge <= 1'b1;
                  s_sel          <= '0;
                  io_read_data   <= s_rw ? sel_data : '0;
               end else if (timeout) begin
                  state          <= ST_RESPOND;
                  io_acknowledge <= 1'b1;
                  s_sel          <= '0;
                  io_read_data   <= s_rw ? ERR_DATA : '0;
               end
            end
            ST_RESPOND: begin
               state        <= ST_RECOVER;
               io_read_data <= '0;
            end
            ST_RECOVER: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

   io_irq_ctrl #(
      .NUM_SLV(NUM_SLV)
   ) u_irq (
      .clk        (clk),
      .reset      (reset),
      .s_irq      (s_irq),
      .mask_wr    (mask_wr),
      .err_wr     (err_wr),
      .byte_enable(io_byte_enable),
      .write_data (io_write_data),
      .err_set    (err_set),
      .err_region (err_region),
      .irq_mask   (irq_mask),
      .err_status (err_status),
      .io_irq     (io_irq)
   );

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl: directed and random requests against a register-level
// model of the I/O bus controller (latency, data, ERR/MASK, io_irq).
module tb_io_bus_ctrl;

   localparam int N  = 4;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            io_bus_enable;
   logic [15:0]     io_address;
   logic            io_rw;
   logic [1:0]      io_byte_enable;
   logic [15:0]     io_write_data;
   logic [15:0]     io_read_data;
   logic            io_acknowledge;
   logic            io_irq;
   logic [N-1:0]    s_sel;
   logic [11:0]     s_address;
   logic            s_rw;
   logic [1:0]      s_byte_enable;
   logic [15:0]     s_write_data;
   logic [16*N-1:0] s_read_data;
   logic [N-1:0]    s_ack;
   logic [N-1:0]    s_irq;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] m_mask;
   logic [15:0] m_err;

   always #5 clk = ~clk;

   io_bus_ctrl #(
      .NUM_SLV(N),
      .TIMEOUT(TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .io_bus_enable (io_bus_enable),
      .io_address    (io_address),
      .io_rw         (io_rw),
      .io_byte_enable(io_byte_enable),
      .io_write_data (io_write_data),
      .io_read_data  (io_read_data),
      .io_acknowledge(io_acknowledge),
      .io_irq        (io_irq),
      .s_sel         (s_sel),
      .s_address     (s_address),
      .s_rw          (s_rw),
      .s_byte_enable (s_byte_enable),
      .s_write_data  (s_write_data),
      .s_read_data   (s_read_data),
      .s_ack         (s_ack),
      .s_irq         (s_irq)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One bridge request; k = cycle in which the selected port acks
   // (k > TO means the port never acks).
   task automatic do_req(input logic [15:0] addr, input logic rw,
                         input logic [1:0] be, input logic [15:0] wd,
                         input int k);
      logic [3:0]  rg;
      logic        periph;
      logic [15:0] pdata [N];
      logic [15:0] exp_data;
      logic [15:0] got_data;
      logic [15:0] bm;
      int          exp_lat;
      int          lat;
      rg       = addr[15:12];
      periph   = int'(rg) < N;
      bm       = {{8{be[1]}}, {8{be[0]}}};
      got_data = '0;
      for (int i = 0; i < N; i++) begin
         pdata[i] = 16'($urandom);
         s_read_data[16*i +: 16] = pdata[i];
      end
      if (rg == 4'hF) begin
         exp_lat  = 1;
         exp_data = 16'h0000;
         if (addr[11:3] == 9'd0) begin
            case (addr[2:1])
               2'd0: exp_data = 16'(s_irq);
               2'd1: exp_data = m_mask;
               2'd2: exp_data = m_err;
               default: exp_data = 16'h0391;
            endcase
            if (!rw && addr[2:1] == 2'd1)
               m_mask = ((m_mask & ~bm) | (wd & bm)) & 16'h800F;
            if (!rw && addr[2:1] == 2'd2)
               m_err = m_err & ~(wd & bm);
         end
      end else if (periph) begin
         if (k <= TO) begin
            exp_lat  = k + 1;
            exp_data = pdata[rg];
         end else begin
            exp_lat      = TO + 1;
            exp_data     = 16'hDEAD;
            m_err[0]     = 1'b1;
            m_err[15:12] = rg;
         end
      end else begin
         exp_lat      = 1;
         exp_data     = 16'hDEAD;
         m_err[1]     = 1'b1;
         m_err[15:12] = rg;
      end
      if (!rw)
         exp_data = 16'h0000;

      @(negedge clk);
      io_bus_enable  = 1'b1;
      io_address     = addr;
      io_rw          = rw;
      io_byte_enable = be;
      io_write_data  = wd;
      s_ack          = '0;
      lat            = 0;
      for (int c = 1; c <= TO + 4; c++) begin
         @(negedge clk);
         if (c == 1 && periph) begin
            chk("s_sel", 32'(s_sel), 32'(1) << rg);
            chk("s_address", 32'(s_address), 32'(addr[11:0]));
            chk("s_write_data", 32'(s_write_data), 32'(wd));
            chk("s_rw_be", {s_rw, s_byte_enable}, {rw, be});
         end
         if (io_acknowledge) begin
            lat      = c;
            got_data = io_read_data;
            break;
         end
         s_ack = N'($urandom);
         if (periph) begin
            s_ack[rg] = 1'b0;
            if (c == k)
               s_ack[rg] = 1'b1;
         end
      end
      if (lat == 0)
         chk("ack_missing", 32'(lat), 32'(exp_lat));
      else begin
         chk("ack_latency", 32'(lat), 32'(exp_lat));
         chk("read_data", 32'(got_data), 32'(exp_data));
      end
      io_bus_enable = 1'b0;
      s_ack         = '0;
      @(negedge clk);
      chk("ack_pulse", 32'(io_acknowledge), 32'(0));
      chk("sel_clear", 32'(s_sel), 32'(0));
   endtask

   task automatic irq_step(input logic [N-1:0] v);
      logic exp;
      s_irq = v;
      exp = (|(v & m_mask[N-1:0])) | (m_mask[15] & (|m_err[1:0]));
      @(negedge clk);
      chk("io_irq", 32'(io_irq), 32'(exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      logic [15:0] a;
      reset          = 1'b1;
      io_bus_enable  = 1'b0;
      io_address     = '0;
      io_rw          = 1'b0;
      io_byte_enable = '0;
      io_write_data  = '0;
      s_read_data    = '0;
      s_ack          = '0;
      s_irq          = '0;
      m_mask         = '0;
      m_err          = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(io_acknowledge), 32'(0));
      chk("rst_rdata", 32'(io_read_data), 32'(0));
      chk("rst_irq", 32'(io_irq), 32'(0));
      chk("rst_sel", 32'(s_sel), 32'(0));
      chk("rst_s_bus", {s_address, s_rw, s_byte_enable, s_write_data},
          32'(0));
      reset = 1'b0;

      do_req(16'hF006, 1'b1, 2'b11, 16'h0000, 0);
      do_req(16'h1004, 1'b0, 2'b11, 16'h1234, 3);
      do_req(16'h2000, 1'b1, 2'b11, 16'h0000, 99);
      do_req(16'hF004, 1'b1, 2'b11, 16'h0000, 0);
      do_req(16'hF004, 1'b0, 2'b11, 16'h0001, 0);
      do_req(16'hF004, 1'b1, 2'b11, 16'h0000, 0);
      do_req(16'h7000, 1'b1, 2'b11, 16'h0000, 0);
      do_req(16'hF004, 1'b1, 2'b11, 16'h0000, 0);
      do_req(16'h3002, 1'b1, 2'b11, 16'h0000, TO);
      do_req(16'h0010, 1'b1, 2'b11, 16'h0000, 1);
      do_req(16'h3000, 1'b0, 2'b01, 16'hBEEF, TO + 1);

      do_req(16'hF002, 1'b0, 2'b11, 16'h0004, 0);
      irq_step(4'b0100);
      irq_step(4'b0001);
      do_req(16'hF002, 1'b0, 2'b10, 16'h80FF, 0);
      do_req(16'hF002, 1'b1, 2'b11, 16'h0000, 0);
      irq_step(4'b0000);
      do_req(16'hF004, 1'b0, 2'b01, 16'h0003, 0);
      irq_step(4'b0000);
      do_req(16'hF00A, 1'b0, 2'b11, 16'hFFFF, 0);
      do_req(16'hF00A, 1'b1, 2'b11, 16'h0000, 0);
      do_req(16'hF000, 1'b1, 2'b11, 16'h0000, 0);

      @(negedge clk);
      io_bus_enable = 1'b1;
      io_address    = 16'h0000;
      io_rw         = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_mid_sel", 32'(s_sel), 32'(0));
      chk("rst_mid_ack", 32'(io_acknowledge), 32'(0));
      io_bus_enable = 1'b0;
      m_mask        = '0;
      m_err         = '0;
      @(negedge clk);
      reset = 1'b0;
      s_ack = '1;
      seen  = 0;
      repeat (4) begin
         @(negedge clk);
         if (io_acknowledge)
            seen++;
      end
      chk("late_ack_ignored", 32'(seen), 32'(0));
      s_ack = '0;
      do_req(16'hF006, 1'b1, 2'b11, 16'h0000, 0);
      do_req(16'h1000, 1'b1, 2'b11, 16'h0000, 2);

      for (int t = 0; t < 150; t++) begin
         a = 16'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            a[15:12] = 4'hF;
            if ($urandom_range(0, 3) != 0)
               a[11:3] = '0;
         end
         do_req(a, 1'($urandom), 2'($urandom), 16'($urandom),
                $urandom_range(1, TO + 2));
         if ($urandom_range(0, 2) == 0)
            irq_step(N'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
